// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default and the prefetch queue entry layout
// for the instruction fetch front-end.
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the IM read port, the decode handshake and the control/status
// signals of fetch_stage; master = the fetch stage, slave = its environment.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_instr;
  // Decode handshake: id_valid/id_instr/id_pc are stable while id_valid is
  // high and not yet taken; the head transfers on any edge with
  // id_valid && id_ready, and id_valid never depends on id_ready.
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [ADDR_W-1:0]  id_pc_plus1;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               halted;
  logic [15:0]        perf_bubble_cnt;

  modport master (
    output im_addr, im_rd_en, id_valid, id_instr, id_pc, id_pc_plus1,
           halted, perf_bubble_cnt,
    input  im_instr, id_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  im_addr, im_rd_en, id_valid, id_instr, id_pc, id_pc_plus1,
           halted, perf_bubble_cnt,
    output im_instr, id_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {instr, pc} entries with push, pop and flush;
// the head entry is presented combinationally from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic [PW:0]  o_count,
  output fetch_entry_t o_head
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  // A pop frees its slot in the same edge, so a push into a full queue is legal then.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: fetch PC, IM issue, in-flight tracking, halt
// and redirect handling. Define FETCH_PERF_EN to build the bubble counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_halt;
  logic [PW:0]       w_count;
  logic [PW+1:0]     w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  fetch_entry_t      w_entry;
  fetch_entry_t      w_head;

  // Occupancy counts the outstanding read so its return always has a slot.
  assign w_occ   = {1'b0, w_count} + {{(PW+1){1'b0}}, r_inflight};
  assign w_issue = rst_n && !bus.redirect && !r_halt && !bus.halt &&
                   (w_occ < (PW+2)'(DEPTH));
  assign w_push  = r_inflight && !bus.redirect;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && bus.id_ready;
  assign w_entry = '{instr: bus.im_instr, pc: r_inflight_pc};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_entry (w_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_halt        <= 1'b0;
    end else begin
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc;
        r_inflight <= 1'b0;
      end else if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end
      if (bus.halt) r_halt <= 1'b1;
    end
  end

  assign bus.im_addr     = r_fetch_pc;
  assign bus.im_rd_en    = w_issue;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_head.instr;
  assign bus.id_pc       = w_head.pc;
  assign bus.id_pc_plus1 = w_head.pc + ADDR_W'(1);
  assign bus.halted      = r_halt && !r_inflight && (w_count == '0);

`ifdef FETCH_PERF_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!w_valid && !r_halt && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.perf_bubble_cnt = r_bubble_cnt;
`else
  assign bus.perf_bubble_cnt = 16'h0000;
`endif

endmodule
